// File: rtl/irq_controller_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_controller_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } irq_state_t;

  localparam logic [7:0] IRQ_PENDING   = 8'h00;
  localparam logic [7:0] IRQ_ENABLE    = 8'h08;
  localparam logic [7:0] IRQ_THRESH    = 8'h10;
  localparam logic [7:0] IRQ_CLAIM     = 8'h18;
  localparam logic [7:0] IRQ_ERR       = 8'h20;
  localparam logic [7:0] IRQ_PRIO_BASE = 8'h40;

  // Byte offset of the priority register for zero-based source index idx.
  function automatic logic [7:0] prio_offset(input int idx);
    return IRQ_PRIO_BASE + 8'(idx * 8);
  endfunction

endpackage

// File: rtl/irq_controller_src_sync.sv
// One interrupt source: synchroniser chain, optional rising-edge detect, pending flop.
module irq_src_sync
  import irq_controller_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter bit EDGE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STG-1:0] sync_q;
  logic                synced;

  assign synced = sync_q[SYNC_STG-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], src};
    end
  end

  if (EDGE) begin : g_edge
    logic synced_d;

    // A new rising edge in the same cycle as a claim keeps the source pending.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        synced_d <= 1'b0;
        pending  <= 1'b0;
      end else begin
        synced_d <= synced;
        pending  <= (synced & ~synced_d) | (pending & ~clr);
      end
    end
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pending <= 1'b0;
      end else begin
        pending <= synced;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source enable/priority, threshold, priority arbitration
// and a claim/complete handshake towards the core, configured over the memory bus.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int               N_SRC     = 8,
  parameter int               PRIO_W    = 3,
  parameter logic [N_SRC-1:0] EDGE_MASK = '0,
  parameter int               SYNC_STG  = 2,
  parameter int               ID_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SRC-1:0] irq_src,
  output logic            irq_req,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ack,
  input  logic            irq_done,
  input  logic [ID_W-1:0] irq_done_id,
  input  logic            bus_sel,
  input  logic [7:0]      bus_address,
  input  logic [63:0]     bus_write_data,
  input  logic            bus_write_enable,
  input  logic            bus_read_enable,
  output logic [63:0]     bus_read_data,
  output logic            irq_err
);

  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  enable;
  logic [N_SRC-1:0]  eligible;
  logic [N_SRC-1:0]  clr;
  logic [PRIO_W-1:0] prio [N_SRC];
  logic [PRIO_W-1:0] thresh;
  logic [PRIO_W-1:0] best_prio;
  logic [ID_W-1:0]   best_id;
  logic [ID_W-1:0]   claimed_id;
  irq_state_t        state, next_state;
  logic              ack_fire, done_fire, err_set;
  logic              wr_hit, rd_hit;
  logic [63:0]       rd_mux;

  assign wr_hit = bus_sel && bus_write_enable;
  assign rd_hit = bus_sel && bus_read_enable;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign clr[g] = ack_fire && (irq_id == ID_W'(g + 1));

    irq_src_sync #(
      .SYNC_STG (SYNC_STG),
      .EDGE     (EDGE_MASK[g])
    ) u_src (
      .clk     (clk),
      .reset   (reset),
      .src     (irq_src[g]),
      .clr     (clr[g]),
      .pending (pending[g])
    );
  end

  // Strict '>' keeps the lowest ID on equal priority.
  always_comb begin
    eligible  = '0;
    best_prio = '0;
    best_id   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = pending[i] && enable[i] && (prio[i] > thresh) && (state == ST_IDLE);
      if (eligible[i] && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (irq_ack && irq_req) next_state = ST_SERVICE;
      ST_SERVICE: if (irq_done && (irq_done_id == claimed_id)) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_fire  = (state == ST_IDLE) && irq_ack && irq_req;
    done_fire = (state == ST_SERVICE) && irq_done && (irq_done_id == claimed_id);
    err_set   = ((state == ST_IDLE) && irq_ack && !irq_req) || (irq_done && !done_fire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_req    <= 1'b0;
      irq_id     <= '0;
      claimed_id <= '0;
      irq_err    <= 1'b0;
    end else begin
      irq_req <= (state == ST_IDLE) && !ack_fire && (best_id != '0);
      irq_id  <= ((state == ST_IDLE) && !ack_fire) ? best_id : '0;
      if (ack_fire) begin
        claimed_id <= irq_id;
      end
      if (wr_hit && (bus_address == IRQ_ERR) && bus_write_data[0]) begin
        irq_err <= 1'b0;
      end else if (err_set) begin
        irq_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= '0;
      thresh <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        prio[i] <= '0;
      end
    end else if (wr_hit) begin
      if (bus_address == IRQ_ENABLE) begin
        enable <= bus_write_data[N_SRC-1:0];
      end
      if (bus_address == IRQ_THRESH) begin
        thresh <= bus_write_data[PRIO_W-1:0];
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (bus_address == prio_offset(i)) begin
          prio[i] <= bus_write_data[PRIO_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus_address)
      IRQ_PENDING: rd_mux[N_SRC-1:0]  = pending;
      IRQ_ENABLE:  rd_mux[N_SRC-1:0]  = enable;
      IRQ_THRESH:  rd_mux[PRIO_W-1:0] = thresh;
      IRQ_CLAIM:   rd_mux[ID_W:0]     = {(state == ST_SERVICE), claimed_id};
      IRQ_ERR:     rd_mux[0]          = irq_err;
      default:     rd_mux             = '0;
    endcase
    for (int i = 0; i < N_SRC; i++) begin
      if (bus_address == prio_offset(i)) begin
        rd_mux[PRIO_W-1:0] = prio[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_read_data <= '0;
    end else begin
      bus_read_data <= rd_hit ? rd_mux : '0;
    end
  end

endmodule
